// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Value presented on ins whenever no real instruction is being delivered.
  localparam logic [31:0] DEFAULT_NOP = 32'h0000_0000;

endpackage

// File: rtl/fetch_sat_counter.sv
// Saturating up-counter with enable and asynchronous active-low clear.
module fetch_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  // Count enabled events; stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives a 1-cycle-latency
// synchronous instruction memory and hands valid-qualified instructions
// to decode, with jump redirect, wrong-path kill, halt and a delivered count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W        = 16,
  parameter int unsigned       INS_W         = 32,
  parameter int unsigned       STEP          = 1,
  parameter logic [ADDR_W-1:0] RESET_VECTOR  = '0,
  parameter logic [INS_W-1:0]  NOP_INS       = INS_W'(DEFAULT_NOP),
  parameter bit                FLUSH_ON_JUMP = 1'b1,
  parameter int unsigned       CNT_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt,
  input  logic              pc_mux_sel,
  input  logic [ADDR_W-1:0] jmp_loc,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [INS_W-1:0]  mem_rdata,
  output logic [INS_W-1:0]  ins,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] current_address,
  output logic [ADDR_W-1:0] next_address,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] STEP_A = ADDR_W'(STEP);

  fetch_state_t      state;
  fetch_state_t      state_nxt;
  logic [ADDR_W-1:0] fetch_pc;
  logic              count_en;

  // State register; reset parks the FSM in BOOT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, fetch address selection and instruction qualification.
  // A jump overrides stall and halt; HALT/stall re-issue the last address
  // so the memory keeps returning the same word.
  always_comb begin
    state_nxt = state;
    mem_addr  = fetch_pc + STEP_A;
    ins_valid = 1'b0;
    unique case (state)
      BOOT: begin
        state_nxt = RUN;
        mem_addr  = RESET_VECTOR;
      end
      RUN: begin
        if (halt && !pc_mux_sel) begin
          state_nxt = HALT;
        end
        ins_valid = !(pc_mux_sel && FLUSH_ON_JUMP);
        if (pc_mux_sel) begin
          mem_addr = jmp_loc;
        end else if (stall) begin
          mem_addr = fetch_pc;
        end
      end
      HALT: begin
        if (pc_mux_sel) begin
          state_nxt = RUN;
          mem_addr  = jmp_loc;
        end else begin
          mem_addr  = fetch_pc;
        end
      end
      default: begin
        state_nxt = BOOT;
        mem_addr  = RESET_VECTOR;
      end
    endcase
    ins = ins_valid ? mem_rdata : NOP_INS;
  end

  // fetch_pc remembers the address issued last cycle, i.e. the address
  // whose data is on mem_rdata now.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_VECTOR;
    end else begin
      fetch_pc <= mem_addr;
    end
  end

  // Link values for decode.
  always_comb begin
    current_address = fetch_pc;
    next_address    = fetch_pc + STEP_A;
  end

  // An instruction counts as delivered when it is valid and consumed.
  always_comb begin
    count_en = ins_valid && !stall;
  end

  fetch_sat_counter #(
    .CNT_W(CNT_W)
  ) u_fetch_count (
    .clk  (clk),
    .clr_n(reset),
    .en   (count_en),
    .count(fetch_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: three parameterisations share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        halt = 1'b0;
  logic        pc_mux_sel = 1'b0;
  logic [15:0] jmp_loc = '0;

  always #5 clk = ~clk;

  logic [15:0] m_addr [3];
  logic [15:0] cur    [3];
  logic [15:0] nxt    [3];
  logic [31:0] ins_o  [3];
  logic [31:0] rdata  [3];
  logic        vld    [3];
  logic [31:0] cnt    [3];
  logic [31:0] cnt_a;
  logic [2:0]  cnt_b;
  logic [7:0]  cnt_c;

  assign cnt[0] = cnt_a;
  assign cnt[1] = {29'd0, cnt_b};
  assign cnt[2] = {24'd0, cnt_c};

  // A: defaults. B: delay-slot mode, 3-bit counter. C: byte step near wrap.
  fetch_unit u_a (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .mem_addr(m_addr[0]),
    .mem_rdata(rdata[0]), .ins(ins_o[0]), .ins_valid(vld[0]),
    .current_address(cur[0]), .next_address(nxt[0]), .fetch_count(cnt_a)
  );

  fetch_unit #(
    .FLUSH_ON_JUMP(1'b0),
    .CNT_W(3)
  ) u_b (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .mem_addr(m_addr[1]),
    .mem_rdata(rdata[1]), .ins(ins_o[1]), .ins_valid(vld[1]),
    .current_address(cur[1]), .next_address(nxt[1]), .fetch_count(cnt_b)
  );

  fetch_unit #(
    .STEP(4),
    .RESET_VECTOR(16'hFFF8),
    .NOP_INS(32'hDEAD_BEEF),
    .CNT_W(8)
  ) u_c (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt),
    .pc_mux_sel(pc_mux_sel), .jmp_loc(jmp_loc), .mem_addr(m_addr[2]),
    .mem_rdata(rdata[2]), .ins(ins_o[2]), .ins_valid(vld[2]),
    .current_address(cur[2]), .next_address(nxt[2]), .fetch_count(cnt_c)
  );

  // Synchronous-read memories: word at addr is 0x1000_0000 + addr.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) rdata[i] <= 32'h1000_0000 + {16'h0000, m_addr[i]};
  end

  // Per-instance configuration as seen by the model.
  logic [15:0]     cfg_rv   [3] = '{16'h0000, 16'h0000, 16'hFFF8};
  logic [15:0]     cfg_step [3] = '{16'd1, 16'd1, 16'd4};
  logic [31:0]     cfg_nop  [3] = '{32'h0, 32'h0, 32'hDEAD_BEEF};
  bit              cfg_flush[3] = '{1'b1, 1'b0, 1'b1};
  longint unsigned cfg_max  [3] = '{64'hFFFF_FFFF, 64'd7, 64'd255};

  // Model state: booting flag, halted flag, address last issued, delivered count.
  bit              mo_boot [3] = '{1'b1, 1'b1, 1'b1};
  bit              mo_halt [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0]     mo_pc   [3] = '{16'h0000, 16'h0000, 16'hFFF8};
  longint unsigned mo_cnt  [3] = '{64'd0, 64'd0, 64'd0};

  int total = 0;
  int bad   = 0;

  function automatic logic [15:0] e_addr(int i);
    if (mo_boot[i])                return cfg_rv[i];
    if (pc_mux_sel)                return jmp_loc;
    if (mo_halt[i] || stall)       return mo_pc[i];
    return mo_pc[i] + cfg_step[i];
  endfunction

  function automatic bit e_valid(int i);
    return !mo_boot[i] && !mo_halt[i] && !(pc_mux_sel && cfg_flush[i]);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Model update on each clock edge; reset takes effect immediately.
  initial begin
    logic [15:0] na;
    bit          nv;
    forever begin
      @(posedge clk or negedge reset);
      for (int i = 0; i < 3; i++) begin
        if (!reset) begin
          mo_boot[i] = 1'b1;
          mo_halt[i] = 1'b0;
          mo_pc[i]   = cfg_rv[i];
          mo_cnt[i]  = 0;
        end else begin
          na = e_addr(i);
          nv = e_valid(i);
          if (nv && !stall && mo_cnt[i] != cfg_max[i]) mo_cnt[i]++;
          if (mo_boot[i])       mo_boot[i] = 1'b0;
          else if (mo_halt[i])  mo_halt[i] = !pc_mux_sel;
          else if (halt && !pc_mux_sel) mo_halt[i] = 1'b1;
          mo_pc[i] = na;
        end
      end
    end
  end

  // Every-cycle comparison of all outputs against the model.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.mem_addr", i), 64'(m_addr[i]), 64'(e_addr(i)));
        chk($sformatf("u%0d.ins_valid", i), 64'(vld[i]), 64'(e_valid(i)));
        chk($sformatf("u%0d.ins", i), 64'(ins_o[i]),
            e_valid(i) ? 64'(32'h1000_0000 + {16'h0000, mo_pc[i]}) : 64'(cfg_nop[i]));
        chk($sformatf("u%0d.current_address", i), 64'(cur[i]), 64'(mo_pc[i]));
        chk($sformatf("u%0d.next_address", i), 64'(nxt[i]), 64'(16'(mo_pc[i] + cfg_step[i])));
        chk($sformatf("u%0d.fetch_count", i), 64'(cnt[i]), 64'(mo_cnt[i]));
      end
    end
  end

  task automatic drive(bit s, bit h, bit j, logic [15:0] t);
    stall = s; halt = h; pc_mux_sel = j; jmp_loc = t;
  endtask

  // Move to the next cycle, apply inputs, then wait to the sampling point.
  task automatic step(bit s, bit h, bit j, logic [15:0] t);
    @(posedge clk); #1;
    drive(s, h, j, t);
    @(negedge clk);
  endtask

  // Directed sequence with hand-computed expectations, then random traffic.
  initial begin
    drive(0, 0, 0, 16'h0);
    repeat (2) @(negedge clk);
    chk("rst.a.mem_addr", 64'(m_addr[0]), 64'h0);
    chk("rst.a.valid", 64'(vld[0]), 64'h0);
    chk("rst.c.mem_addr", 64'(m_addr[2]), 64'hFFF8);

    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rel.a.mem_addr", 64'(m_addr[0]), 64'h0);
    chk("rel.a.valid", 64'(vld[0]), 64'h0);
    chk("rel.a.ins", 64'(ins_o[0]), 64'h0);
    chk("rel.c.ins", 64'(ins_o[2]), 64'hDEAD_BEEF);

    step(0, 0, 0, 16'h0);
    chk("first.a.ins", 64'(ins_o[0]), 64'h1000_0000);
    chk("first.a.valid", 64'(vld[0]), 64'h1);
    chk("first.a.cur", 64'(cur[0]), 64'h0);
    chk("first.a.nxt", 64'(nxt[0]), 64'h1);
    chk("first.c.ins", 64'(ins_o[2]), 64'h1000_FFF8);

    step(0, 0, 0, 16'h0);
    chk("second.a.ins", 64'(ins_o[0]), 64'h1000_0001);
    chk("second.c.cur", 64'(cur[2]), 64'hFFFC);
    chk("second.c.nxt", 64'(nxt[2]), 64'h0000);

    repeat (3) step(0, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    chk("stall.a.ins", 64'(ins_o[0]), 64'h1000_0005);
    chk("stall.a.mem_addr", 64'(m_addr[0]), 64'h5);
    chk("stall.a.cnt", 64'(cnt[0]), 64'd5);
    repeat (2) begin
      step(1, 0, 0, 16'h0);
      chk("stall.a.ins_hold", 64'(ins_o[0]), 64'h1000_0005);
      chk("stall.a.cur_hold", 64'(cur[0]), 64'h5);
      chk("stall.a.cnt_hold", 64'(cnt[0]), 64'd5);
    end
    step(0, 0, 0, 16'h0);
    chk("unstall.a.mem_addr", 64'(m_addr[0]), 64'h6);
    step(0, 0, 0, 16'h0);
    chk("unstall.a.ins", 64'(ins_o[0]), 64'h1000_0006);
    chk("unstall.a.cnt", 64'(cnt[0]), 64'd6);

    step(0, 0, 1, 16'h0040);
    chk("jmp.a.valid", 64'(vld[0]), 64'h0);
    chk("jmp.a.ins", 64'(ins_o[0]), 64'h0);
    chk("jmp.a.mem_addr", 64'(m_addr[0]), 64'h40);
    chk("jmp.b.ins", 64'(ins_o[1]), 64'h1000_0007);
    chk("jmp.b.valid", 64'(vld[1]), 64'h1);
    step(0, 0, 0, 16'h0);
    chk("jmp.a.target", 64'(ins_o[0]), 64'h1000_0040);
    chk("jmp.a.cnt", 64'(cnt[0]), 64'd7);

    step(1, 1, 1, 16'h0080);
    chk("jsh.a.mem_addr", 64'(m_addr[0]), 64'h80);
    step(0, 0, 0, 16'h0);
    chk("jsh.a.target", 64'(ins_o[0]), 64'h1000_0080);
    chk("jsh.a.valid", 64'(vld[0]), 64'h1);

    step(0, 0, 1, 16'h0003);
    step(0, 1, 0, 16'h0);
    chk("halt.a.ins", 64'(ins_o[0]), 64'h1000_0003);
    chk("halt.a.valid", 64'(vld[0]), 64'h1);
    for (int k = 0; k < 4; k++) begin
      step(0, k[0], 0, 16'h0);
      chk("halted.a.valid", 64'(vld[0]), 64'h0);
      chk("halted.a.mem_addr", 64'(m_addr[0]), 64'h4);
      chk("halted.a.cnt", 64'(cnt[0]), 64'd10);
    end
    step(0, 0, 1, 16'h0010);
    step(0, 0, 0, 16'h0);
    chk("resume.a.ins", 64'(ins_o[0]), 64'h1000_0010);
    chk("resume.a.valid", 64'(vld[0]), 64'h1);

    step(0, 0, 1, 16'hFFFF);
    step(0, 0, 0, 16'h0);
    chk("wrap.a.ins_ffff", 64'(ins_o[0]), 64'h1000_FFFF);
    chk("wrap.a.nxt", 64'(nxt[0]), 64'h0);
    step(0, 0, 0, 16'h0);
    chk("wrap.a.ins_0", 64'(ins_o[0]), 64'h1000_0000);
    chk("wrap.a.cur", 64'(cur[0]), 64'h0);
    chk("sat.b.cnt", 64'(cnt[1]), 64'd7);

    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrst.a.valid", 64'(vld[0]), 64'h0);
    chk("midrst.a.cur", 64'(cur[0]), 64'h0);
    chk("midrst.a.cnt", 64'(cnt[0]), 64'd0);
    chk("midrst.c.cur", 64'(cur[2]), 64'hFFF8);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("reboot.a.valid", 64'(vld[0]), 64'h0);
    step(0, 0, 0, 16'h0);
    chk("reboot.a.ins", 64'(ins_o[0]), 64'h1000_0000);

    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 99) >= 2);
      drive($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 10, 16'($urandom));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(0, 0, 0, 16'h0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
